// File: rtl/edge_window_ctrl.sv
// edge_window_ctrl: 3x3 window sequencer in front of the edge detector.
// Takes a raster-order 10-bit pixel stream and keeps two line buffers plus a
// 3x3 window. It presents the window, a frame-stable threshold and
// coordinate/valid sideband aligned with the detector's registered output.
// Optional build macro: EDGE_WIN_STATS_EN (per-frame window counter on oGridCount).
module edge_window_ctrl #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int DET_LAT = 1
) (
    input  logic        clock,
    input  logic        iReset_n,
    input  logic        iSOF,
    input  logic        iValid,
    input  logic [9:0]  iPixel,
    input  logic [9:0]  iThreshold,
    output logic [89:0] oGrid,
    output logic        oGridValid,
    output logic [9:0]  oThreshold,
    output logic        oPixelValid,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic        oBusy,
    output logic        oFrameDone,
    output logic [19:0] oGridCount
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   col_r, col_next_s, acc_col_s;
    logic [RW-1:0]   row_r, row_next_s, acc_row_s;
    logic            accept_s, last_s, win_ok_s;
    logic [9:0]      lb0_r [IMG_W];
    logic [9:0]      lb1_r [IMG_W];
    logic [9:0]      lb0_rd_s, lb1_rd_s;
    logic [89:0]     grid_shift_s;
    logic [9:0]      grid_x_r, grid_y_r;
    logic            pv_pipe_r [DET_LAT];
    logic [9:0]      x_pipe_r  [DET_LAT];
    logic [9:0]      y_pipe_r  [DET_LAT];

    // Pixel acceptance, coordinate of the accepted pixel and counter advance.
    // A start-of-frame makes the same-cycle pixel land at (0,0).
    always_comb begin
        acc_col_s  = iSOF ? {CW{1'b0}} : col_r;
        acc_row_s  = iSOF ? {RW{1'b0}} : row_r;
        accept_s   = iValid && (iSOF || (state_r == ACTIVE));
        last_s     = accept_s && (acc_col_s == CW'(IMG_W - 1)) && (acc_row_s == RW'(IMG_H - 1));
        win_ok_s   = accept_s && (acc_col_s >= CW'(2)) && (acc_row_s >= RW'(2));
        col_next_s = acc_col_s;
        row_next_s = acc_row_s;
        if (accept_s) begin
            if (acc_col_s == CW'(IMG_W - 1)) begin
                col_next_s = {CW{1'b0}};
                if (acc_row_s == RW'(IMG_H - 1)) begin
                    row_next_s = {RW{1'b0}};
                end else begin
                    row_next_s = acc_row_s + RW'(1);
                end
            end else begin
                col_next_s = acc_col_s + CW'(1);
            end
        end else begin
            col_next_s = acc_col_s;
        end
    end

    // Next-state logic: iSOF restarts the frame from any state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (iSOF) state_s = ACTIVE;
                else      state_s = IDLE;
            end
            ACTIVE: begin
                if (iSOF)        state_s = ACTIVE;
                else if (last_s) state_s = DONE;
                else             state_s = ACTIVE;
            end
            DONE: begin
                if (iSOF) state_s = ACTIVE;
                else      state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Line buffer read ports and the shifted window: new column enters at c=0.
    always_comb begin
        lb0_rd_s     = lb0_r[acc_col_s];
        lb1_rd_s     = lb1_r[acc_col_s];
        grid_shift_s = {oGrid[79:60], lb1_rd_s, oGrid[49:30], lb0_rd_s, oGrid[19:0], iPixel};
    end

    // Line buffers are deliberately not reset; stale rows are masked by row<2.
    always_ff @(posedge clock) begin
        if (accept_s) begin
            lb1_r[acc_col_s] <= lb0_r[acc_col_s];
            lb0_r[acc_col_s] <= iPixel;
        end
    end

    // State, counters, window, threshold and status registers.
    always_ff @(posedge clock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_r    <= IDLE;
            col_r      <= {CW{1'b0}};
            row_r      <= {RW{1'b0}};
            oGrid      <= 90'd0;
            oGridValid <= 1'b0;
            grid_x_r   <= 10'd0;
            grid_y_r   <= 10'd0;
            oThreshold <= 10'd0;
            oBusy      <= 1'b0;
            oFrameDone <= 1'b0;
        end else begin
            state_r    <= state_s;
            col_r      <= col_next_s;
            row_r      <= row_next_s;
            oGridValid <= win_ok_s;
            oBusy      <= (state_s == ACTIVE);
            oFrameDone <= (state_s == DONE);
            if (accept_s) begin
                oGrid <= grid_shift_s;
            end
            if (win_ok_s) begin
                grid_x_r <= 10'(acc_col_s - CW'(1));
                grid_y_r <= 10'(acc_row_s - RW'(1));
            end
            if (iSOF) begin
                oThreshold <= iThreshold;
            end
        end
    end

    // Sideband delay line matching detector latency; iSOF flushes valid bits.
    always_ff @(posedge clock or negedge iReset_n) begin
        if (!iReset_n) begin
            for (int i = 0; i < DET_LAT; i++) begin
                pv_pipe_r[i] <= 1'b0;
                x_pipe_r[i]  <= 10'd0;
                y_pipe_r[i]  <= 10'd0;
            end
        end else begin
            pv_pipe_r[0] <= iSOF ? 1'b0 : oGridValid;
            x_pipe_r[0]  <= grid_x_r;
            y_pipe_r[0]  <= grid_y_r;
            for (int i = 1; i < DET_LAT; i++) begin
                pv_pipe_r[i] <= iSOF ? 1'b0 : pv_pipe_r[i-1];
                x_pipe_r[i]  <= x_pipe_r[i-1];
                y_pipe_r[i]  <= y_pipe_r[i-1];
            end
        end
    end

    assign oPixelValid = pv_pipe_r[DET_LAT-1];
    assign oX          = x_pipe_r[DET_LAT-1];
    assign oY          = y_pipe_r[DET_LAT-1];

`ifdef EDGE_WIN_STATS_EN
    logic [19:0] win_cnt_r;

    // Windows emitted in the current frame; restarted by every iSOF.
    always_ff @(posedge clock or negedge iReset_n) begin
        if (!iReset_n) begin
            win_cnt_r <= 20'd0;
        end else if (iSOF) begin
            win_cnt_r <= 20'd0;
        end else if (oGridValid) begin
            win_cnt_r <= win_cnt_r + 20'd1;
        end else begin
            win_cnt_r <= win_cnt_r;
        end
    end

    // Publish the count in DONE, including the final window still on oGridValid.
    always_ff @(posedge clock or negedge iReset_n) begin
        if (!iReset_n) begin
            oGridCount <= 20'd0;
        end else if (state_r == DONE) begin
            oGridCount <= win_cnt_r + {19'd0, oGridValid};
        end else begin
            oGridCount <= oGridCount;
        end
    end
`else
    assign oGridCount = 20'd0;
`endif

endmodule

// File: tb/tb_edge_window_ctrl.sv
// Self-checking bench for edge_window_ctrl (8x4 image, DET_LAT=1).
// A frame-level model (pixel image array, window count, delay line) predicts
// every output each cycle; directed frames pin the model with literal values.
module tb_edge_window_ctrl;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int DL = 1;

    logic        clock = 1'b0;
    logic        iReset_n = 1'b0;
    logic        iSOF = 1'b0;
    logic        iValid = 1'b0;
    logic [9:0]  iPixel = 10'd0;
    logic [9:0]  iThreshold = 10'd0;
    logic [89:0] oGrid;
    logic        oGridValid, oPixelValid, oBusy, oFrameDone;
    logic [9:0]  oThreshold, oX, oY;
    logic [19:0] oGridCount;

    edge_window_ctrl #(.IMG_W(W), .IMG_H(H), .DET_LAT(DL)) dut (
        .clock(clock), .iReset_n(iReset_n), .iSOF(iSOF), .iValid(iValid),
        .iPixel(iPixel), .iThreshold(iThreshold), .oGrid(oGrid),
        .oGridValid(oGridValid), .oThreshold(oThreshold), .oPixelValid(oPixelValid),
        .oX(oX), .oY(oY), .oBusy(oBusy), .oFrameDone(oFrameDone), .oGridCount(oGridCount)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [89:0] act, input logic [89:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          img [H][W];
    int          m_n, frame_wins, g_x, g_y, mc, mr;
    bit          m_act, m_done, was_done, acc;
    bit          e_gv, e_pv, e_busy, e_fd;
    logic [89:0] e_grid;
    logic [9:0]  e_thr;
    logic [19:0] e_cnt;
    int          e_x, e_y;
    bit          q_v [DL];
    int          q_x [DL];
    int          q_y [DL];

    always @(posedge clock or negedge iReset_n) begin
        if (!iReset_n) begin
            m_n = 0; frame_wins = 0; g_x = 0; g_y = 0;
            m_act = 0; m_done = 0;
            e_gv = 0; e_pv = 0; e_busy = 0; e_fd = 0;
            e_grid = '0; e_thr = '0; e_cnt = '0; e_x = 0; e_y = 0;
            for (int i = 0; i < DL; i++) begin q_v[i] = 0; q_x[i] = 0; q_y[i] = 0; end
        end else begin
            was_done = m_done;
            // delay line of (valid, x, y): newest at index 0, output is the oldest
            for (int i = DL - 1; i > 0; i--) begin
                q_v[i] = iSOF ? 1'b0 : q_v[i-1]; q_x[i] = q_x[i-1]; q_y[i] = q_y[i-1];
            end
            q_v[0] = iSOF ? 1'b0 : e_gv; q_x[0] = g_x; q_y[0] = g_y;
            e_pv = q_v[DL-1]; e_x = q_x[DL-1]; e_y = q_y[DL-1];
`ifdef EDGE_WIN_STATS_EN
            if (was_done) e_cnt = 20'(frame_wins);
`endif
            if (iSOF) begin
                m_n = 0; frame_wins = 0; e_thr = iThreshold;
            end
            acc = iValid && (iSOF || m_act);
            e_gv = 0;
            if (acc) begin
                mc = m_n % W; mr = m_n / W;
                img[mr][mc] = int'(iPixel);
                if (mc >= 2 && mr >= 2) begin
                    e_gv = 1; frame_wins++;
                    for (int rr = 0; rr < 3; rr++)
                        for (int cc = 0; cc < 3; cc++)
                            e_grid[10*(3*rr+cc) +: 10] = 10'(img[mr-rr][mc-cc]);
                    g_x = mc - 1; g_y = mr - 1;
                end
                m_n++;
            end
            if (iSOF) begin
                m_act = 1; m_done = 0;
            end else if (m_act && acc && m_n == W * H) begin
                m_act = 0; m_done = 1;
            end else if (m_done) begin
                m_done = 0;
            end
            e_busy = m_act; e_fd = m_done;
        end
    end

    // ---------------- monitor / compare ----------------
    int cyc = 0;
    int gv_cyc[$], gv_t00[$], gv_t22[$];
    int pv_cyc[$], pv_x[$], pv_y[$];
    int fd_cyc[$];

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (iReset_n) begin
            check("grid_valid", oGridValid, e_gv);
            check("pixel_valid", oPixelValid, e_pv);
            check("threshold", oThreshold, e_thr);
            check("busy", oBusy, e_busy);
            check("frame_done", oFrameDone, e_fd);
            check("grid_count", oGridCount, e_cnt);
            if (e_gv) check("grid", oGrid, e_grid);
            if (e_pv) begin
                check("x", oX, 10'(e_x));
                check("y", oY, 10'(e_y));
            end
            if (oGridValid) begin
                gv_cyc.push_back(cyc); gv_t00.push_back(int'(oGrid[9:0])); gv_t22.push_back(int'(oGrid[89:80]));
            end
            if (oPixelValid) begin
                pv_cyc.push_back(cyc); pv_x.push_back(int'(oX)); pv_y.push_back(int'(oY));
            end
            if (oFrameDone) fd_cyc.push_back(cyc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit sof, input bit v, input int pix, input int thr);
        @(negedge clock);
        iSOF = sof; iValid = v; iPixel = 10'(pix); iThreshold = 10'(thr);
    endtask

    int g0, p0, d0, c18, c31;

    initial begin
        repeat (3) @(negedge clock);
        check("reset_grid", oGrid, 90'd0);
        check("reset_gv", oGridValid, 1'b0);
        check("reset_thr", oThreshold, 10'd0);
        check("reset_busy", oBusy, 1'b0);
        iReset_n = 1'b1;
        step(0, 1, 5, 0);   // ignored in IDLE
        step(0, 0, 0, 0);

        // Frame 1: back-to-back pixels value=index
        g0 = gv_cyc.size(); p0 = pv_cyc.size(); d0 = fd_cyc.size();
        step(1, 0, 0, 100);
        for (int i = 0; i < W * H; i++) begin
            step(0, 1, i, 0);
            if (i == 18) c18 = cyc;
            if (i == 31) c31 = cyc;
        end
        repeat (4) step(0, 0, 0, 0);
        check("f1_windows", gv_cyc.size() - g0, 12);
        check("f1_first_cyc", gv_cyc[g0], c18 + 1);
        check("f1_tap00", gv_t00[g0], 18);
        check("f1_tap22", gv_t22[g0], 0);
        check("f1_done_cnt", fd_cyc.size() - d0, 1);
        check("f1_done_cyc", fd_cyc[d0], c31 + 1);
        check("f1_thr", oThreshold, 10'd100);
        check("f1_pv_first_cyc", pv_cyc[p0], c18 + 2);
        check("f1_first_x", pv_x[p0], 1);
        check("f1_first_y", pv_y[p0], 1);
        check("f1_last_x", pv_x[pv_x.size()-1], 6);
        check("f1_last_y", pv_y[pv_y.size()-1], 2);
`ifdef EDGE_WIN_STATS_EN
        check("f1_stats", oGridCount, 20'd12);
`else
        check("f1_stats_off", oGridCount, 20'd0);
`endif

        // Frame 2: iValid toggled every cycle
        g0 = gv_cyc.size();
        step(1, 0, 0, 100);
        for (int i = 0; i < W * H; i++) begin
            step(0, 1, i, 0);
            step(0, 0, 0, 0);
        end
        repeat (3) step(0, 0, 0, 0);
        check("f2_windows", gv_cyc.size() - g0, 12);
        check("f2_first_tap00", gv_t00[g0], 18);
        check("f2_last_tap00", gv_t00[gv_t00.size()-1], 31);
`ifdef EDGE_WIN_STATS_EN
        check("f2_stats", oGridCount, 20'd12);
`endif

        // Abort after 20 pixels, restart with threshold 55
        g0 = gv_cyc.size(); d0 = fd_cyc.size();
        step(1, 0, 0, 100);
        for (int i = 0; i < 20; i++) step(0, 1, i + 300, 0);
        step(1, 0, 0, 55);
        step(0, 0, 0, 0);
        check("abort_no_done", fd_cyc.size() - d0, 0);
        check("abort_thr", oThreshold, 10'd55);
`ifdef EDGE_WIN_STATS_EN
        check("abort_stats_hold", oGridCount, 20'd12);
`endif
        for (int i = 0; i < W * H; i++) begin
            step(0, 1, i, 0);
            if (i == 18) c18 = cyc;
        end
        repeat (3) step(0, 0, 0, 0);
        check("abort_windows", gv_cyc.size() - g0, 14);
        check("abort_first_cyc", gv_cyc[g0+2], c18 + 1);
        check("abort_tap00", gv_t00[g0+2], 18);
        check("abort_done_cnt", fd_cyc.size() - d0, 1);

        // Asynchronous reset mid-frame
        step(1, 0, 0, 77);
        for (int i = 0; i < 10; i++) step(0, 1, i, 0);
        @(posedge clock);
        #2 iReset_n = 1'b0;
        #1;
        check("arst_grid", oGrid, 90'd0);
        check("arst_gv", oGridValid, 1'b0);
        check("arst_pv", oPixelValid, 1'b0);
        check("arst_xy", {oX, oY}, 20'd0);
        check("arst_thr", oThreshold, 10'd0);
        check("arst_busy", oBusy, 1'b0);
        check("arst_done", oFrameDone, 1'b0);
        check("arst_count", oGridCount, 20'd0);
        #9 iReset_n = 1'b1;
        g0 = gv_cyc.size();
        for (int i = 0; i < W * H; i++) step(0, 1, i, 0);
        step(0, 0, 0, 0);
        check("arst_ignored", gv_cyc.size() - g0, 0);
        check("arst_idle_busy", oBusy, 1'b0);
        step(1, 1, 0, 9);
        for (int i = 1; i < W * H; i++) step(0, 1, i, 0);
        repeat (3) step(0, 0, 0, 0);
        check("arst_refr", gv_cyc.size() - g0, 12);

        // Randomized traffic against the model
        step(1, 0, 0, 200);
        for (int k = 0; k < 3000; k++) begin
            bit s;
            s = ($urandom_range(0, 149) == 0);
            step(s, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        end
        repeat (5) step(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
